keyboard_entry_decoder: RTL
===========================

// Module: keyboard_entry_decoder
// PURPOSE
//  Clocked, parametrised PS/2 scan-code decoder for the microwave front end. Sits between the PS/2
//  receiver and the control FSM. Turns make codes into:
//    - an enter pulse;
//    - an N-digit BCD cook-time entry with backspace/clear;
//    - an auto-cook mode select.
//  Filters break (F0) and extended (E0) prefixes, so a release never registers as a keypress.
// PARAMETERS
//  NUM_DIGITS   4  BCD digits held in the time-entry buffer (1..8)
//  DROP_OLDEST  1  1: a digit entered when full shifts out the MS digit; 0: the digit is ignored
// PORTS
//  clock          in   1             system clock; all state updates on its rising edge
//  reset          in   1             asynchronous, active-high; clears all state
//  keyValid       in   1             1-cycle strobe from the PS/2 receiver; keyCode is valid this cycle
//  keyCode        in   8             scan-code byte (make, F0 or E0)
//  checkLoad      in   1             FSM is waiting for enter (time or heat-level state)
//  checkDuration  in   1             FSM is in the time-entry state
//  selectAuto     in   1             FSM is in auto-mode select
//  enterOut       out  1             1-cycle pulse: enter accepted
//  durationOut    out  4*NUM_DIGITS  BCD time entry; digit 0 = bits [3:0] = most recently entered
//  digitCount     out  clog2(N+1)    number of digits currently held (0..NUM_DIGITS)
//  digitStrobe    out  1             1-cycle pulse: the buffer changed (digit added, deleted or cleared)
//  autoOut        out  3             auto mode: 0 popcorn, 1 potato, 2 meat, 3 veg, 4 beverage,
//                                    5 reheat, 6 defrost, 7 auto
//  autoSet        out  1             1-cycle pulse: valid auto key accepted
// BEHAVIOUR
//  Reset: all outputs 0; prefix FSM returns to IDLE.
//  Latency: every output updates on the clock edge that samples keyValid=1 (registered, 1 cycle).
//  Prefix FSM (advances only when keyValid=1):
//    IDLE: F0 -> BRK; E0 -> EXT; any other code is a make -> decode.
//    EXT:  F0 -> EXTBRK; 5A -> decode as enter, go to IDLE; other codes ignored, go to IDLE.
//    BRK, EXTBRK: the next code is swallowed, go to IDLE.
//  Decode of a make code, in priority order:
//    5A (or E0 5A) with checkLoad|checkDuration -> enterOut=1 for one cycle. Buffer is unchanged.
//    Digit with checkDuration -> shift the buffer left by 4 bits; the new digit goes into [3:0].
//      Numpad codes:  70,69,72,7A,6B,73,74,6C,75,7D = 0..9
//      Top-row codes: 45,16,1E,26,25,2E,36,3D,3E,46 = 0..9
//      digitCount increments, saturating at NUM_DIGITS.
//      When full: DROP_OLDEST=1 shifts anyway (MS digit lost); DROP_OLDEST=0 leaves the buffer alone
//      and gives no strobe.
//    66 (backspace) with checkDuration and digitCount>0 -> shift right by 4 with zero fill; count-1.
//      With digitCount=0 it does nothing and gives no strobe.
//    76 (esc) with checkDuration -> buffer=0, count=0, strobe=1 (strobe even if already empty).
//    Auto keys with selectAuto -> autoOut=mode, autoSet=1:
//      4D=0, 44=1, 3A=2, 2A=3, 32=4, 2D=5, 23=6, 1C=7.
//      Any other make code: autoOut holds, autoSet=0.
//    Any other code or state combination -> no output change.
//  Rising edge of checkDuration (registered compare) clears the buffer and count.
//    The clear has no strobe.
//    If a digit key is accepted in that same cycle, it lands in the cleared buffer and count=1.
//  durationOut and autoOut hold their values between keys.
//  enterOut, autoSet and digitStrobe are never high longer than one cycle.
//  keyValid is assumed to be at most 1 per 2 cycles. Back-to-back keyValid is still processed
//    one code per cycle.
//  Asserting reset mid-sequence (e.g. after F0) aborts the sequence; the next code decodes from IDLE.
// CONFIGURATION
//  KEY_REPEAT_FILTER_EN defined: a make code equal to the previous make code, with no break code
//    in between, is ignored (typematic repeat). A break code clears the stored last code.
//    Reset clears the stored last code as well.
//  KEY_REPEAT_FILTER_EN undefined: every make code is decoded, so holding a key repeats its digit.
// TESTING
//  1. reset; checkDuration=1; keys 16,1E,26,25 -> durationOut=16'h1234, digitCount=4, four strobes.
//  2. continue with 45, DROP_OLDEST=1 -> durationOut=16'h2340.
//     Same sequence with DROP_OLDEST=0 -> stays 16'h1234 and no strobe.
//  3. 69,72 then 66 -> durationOut=16'h0001, count=1.
//     Then F0 69 (a release) -> no change. Then 76 -> 16'h0000, count=0, strobe.
//  4. checkLoad=1, E0 5A -> enterOut high exactly 1 cycle.
//     Then E0 F0 5A -> no pulse.
//  5. selectAuto=1; 3A -> autoOut=2, autoSet pulse. Then 29 -> autoOut=2, no pulse.
//     selectAuto=0; 1C -> no change.
//  6. KEY_REPEAT_FILTER_EN defined: 69,69,F0 69,69 -> durationOut=16'h0011.
//     Undefined: the same sequence gives 16'h0111.

Source files
------------

// File: rtl/keyboard_entry_decoder.sv
// Purpose: PS/2 scan-code decoder producing an enter pulse, an N-digit BCD time entry and an auto-mode select.
// Latency: 1 cycle; every output is registered on the edge that samples i_keyValid.
// Backpressure: none; one code is accepted per i_keyValid strobe. Option macro KEY_REPEAT_FILTER_EN drops typematic repeats.
module keyboard_entry_decoder #(
    parameter int  NUM_DIGITS  = 4,
    parameter bit  DROP_OLDEST = 1'b1,
    localparam int CW          = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_keyValid,
    input  logic [7:0]              i_keyCode,
    input  logic                    i_checkLoad,
    input  logic                    i_checkDuration,
    input  logic                    i_selectAuto,
    output logic                    o_enterOut,
    output logic [4*NUM_DIGITS-1:0] o_durationOut,
    output logic [CW-1:0]           o_digitCount,
    output logic                    o_digitStrobe,
    output logic [2:0]              o_autoOut,
    output logic                    o_autoSet
);

    localparam logic [7:0] C_BRK   = 8'hF0;
    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_ENTER = 8'h5A;
    localparam logic [7:0] C_BKSP  = 8'h66;
    localparam logic [7:0] C_ESC   = 8'h76;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;

    state_t                  r_state;
    logic                    r_dur_d;
    logic [4*NUM_DIGITS-1:0] r_buf;
    logic [CW-1:0]           r_cnt;
    logic                    r_enter;
    logic                    r_strobe;
    logic [2:0]              r_auto;
    logic                    r_set;

    logic                    w_make_raw;
    logic                    w_repeat;
    logic                    w_make;
    logic                    w_dur_rise;
    logic [4:0]              w_digit;
    logic [3:0]              w_auto;
    logic                    w_full;
    logic [4*NUM_DIGITS-1:0] w_buf_base;
    logic [CW-1:0]           w_cnt_base;
    logic [4*NUM_DIGITS-1:0] w_shl;
    logic [4*NUM_DIGITS-1:0] w_buf_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_strobe_nxt;
    logic                    w_enter_nxt;
    logic [2:0]              w_auto_nxt;
    logic                    w_set_nxt;

    // Both keypads map to the same BCD value: {valid, digit}
    function automatic logic [4:0] f_digit(input logic [7:0] c);
        case (c)
            8'h70, 8'h45: f_digit = {1'b1, 4'd0};
            8'h69, 8'h16: f_digit = {1'b1, 4'd1};
            8'h72, 8'h1E: f_digit = {1'b1, 4'd2};
            8'h7A, 8'h26: f_digit = {1'b1, 4'd3};
            8'h6B, 8'h25: f_digit = {1'b1, 4'd4};
            8'h73, 8'h2E: f_digit = {1'b1, 4'd5};
            8'h74, 8'h36: f_digit = {1'b1, 4'd6};
            8'h6C, 8'h3D: f_digit = {1'b1, 4'd7};
            8'h75, 8'h3E: f_digit = {1'b1, 4'd8};
            8'h7D, 8'h46: f_digit = {1'b1, 4'd9};
            default:      f_digit = 5'd0;
        endcase
    endfunction

    // Auto-cook keys: {valid, mode}
    function automatic logic [3:0] f_auto(input logic [7:0] c);
        case (c)
            8'h4D:   f_auto = {1'b1, 3'd0};
            8'h44:   f_auto = {1'b1, 3'd1};
            8'h3A:   f_auto = {1'b1, 3'd2};
            8'h2A:   f_auto = {1'b1, 3'd3};
            8'h32:   f_auto = {1'b1, 3'd4};
            8'h2D:   f_auto = {1'b1, 3'd5};
            8'h23:   f_auto = {1'b1, 3'd6};
            8'h1C:   f_auto = {1'b1, 3'd7};
            default: f_auto = 4'd0;
        endcase
    endfunction

    // A make is a plain code from IDLE, or the only extended code we honour (E0 5A)
    assign w_make_raw = i_keyValid &&
                        (((r_state == S_IDLE) && (i_keyCode != C_BRK) && (i_keyCode != C_EXT)) ||
                         ((r_state == S_EXT) && (i_keyCode == C_ENTER)));
    assign w_make     = w_make_raw && !w_repeat;
    assign w_dur_rise = i_checkDuration && !r_dur_d;
    assign w_digit    = f_digit(i_keyCode);
    assign w_auto     = f_auto(i_keyCode);

`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0] r_last_code;
    logic       r_last_vld;
    logic       w_break;

    assign w_break  = i_keyValid && (i_keyCode == C_BRK) &&
                      ((r_state == S_IDLE) || (r_state == S_EXT));
    assign w_repeat = r_last_vld && (r_last_code == i_keyCode);

    // Remember the last make code until a break code arrives
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last_code <= 8'h00;
            r_last_vld  <= 1'b0;
        end else if (w_break) begin
            r_last_vld  <= 1'b0;
        end else if (w_make_raw) begin
            r_last_code <= i_keyCode;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // Prefix FSM: swallow the code after F0, honour only 5A after E0
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else if (i_keyValid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_keyCode == C_BRK)      r_state <= S_BRK;
                    else if (i_keyCode == C_EXT) r_state <= S_EXT;
                    else                         r_state <= S_IDLE;
                end
                S_EXT:   r_state <= (i_keyCode == C_BRK) ? S_EXTBRK : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Next-state of the entry buffer and pulse outputs; the checkDuration rise clears first
    always_comb begin
        w_buf_base   = w_dur_rise ? '0 : r_buf;
        w_cnt_base   = w_dur_rise ? '0 : r_cnt;
        w_full       = (w_cnt_base == CW'(NUM_DIGITS));
        w_shl        = w_buf_base << 4;
        w_shl[3:0]   = w_digit[3:0];
        w_buf_nxt    = w_buf_base;
        w_cnt_nxt    = w_cnt_base;
        w_strobe_nxt = 1'b0;
        w_enter_nxt  = 1'b0;
        w_auto_nxt   = r_auto;
        w_set_nxt    = 1'b0;
        if (w_make) begin
            if ((i_keyCode == C_ENTER) && (i_checkLoad || i_checkDuration)) begin
                w_enter_nxt = 1'b1;
            end else if (w_digit[4] && i_checkDuration) begin
                if (!w_full) begin
                    w_buf_nxt    = w_shl;
                    w_cnt_nxt    = w_cnt_base + CW'(1);
                    w_strobe_nxt = 1'b1;
                end else if (DROP_OLDEST) begin
                    w_buf_nxt    = w_shl;
                    w_strobe_nxt = 1'b1;
                end
            end else if ((i_keyCode == C_BKSP) && i_checkDuration) begin
                if (w_cnt_base != '0) begin
                    w_buf_nxt    = w_buf_base >> 4;
                    w_cnt_nxt    = w_cnt_base - CW'(1);
                    w_strobe_nxt = 1'b1;
                end
            end else if ((i_keyCode == C_ESC) && i_checkDuration) begin
                w_buf_nxt    = '0;
                w_cnt_nxt    = '0;
                w_strobe_nxt = 1'b1;
            end else if (w_auto[3] && i_selectAuto) begin
                w_auto_nxt = w_auto[2:0];
                w_set_nxt  = 1'b1;
            end
        end
    end

    // Register all outputs and the checkDuration history
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_dur_d  <= 1'b0;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_enter  <= 1'b0;
            r_strobe <= 1'b0;
            r_auto   <= 3'd0;
            r_set    <= 1'b0;
        end else begin
            r_dur_d  <= i_checkDuration;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_enter  <= w_enter_nxt;
            r_strobe <= w_strobe_nxt;
            r_auto   <= w_auto_nxt;
            r_set    <= w_set_nxt;
        end
    end

    assign o_enterOut    = r_enter;
    assign o_durationOut = r_buf;
    assign o_digitCount  = r_cnt;
    assign o_digitStrobe = r_strobe;
    assign o_autoOut     = r_auto;
    assign o_autoSet     = r_set;

endmodule
